fifo_sync: RTL and testbench
============================

Name: fifo_sync

Overview:
- Synchronous single-clock FIFO; the producer side of the get/empty read interface used by the prefetch stage.
- Write side: put/full. Read side: show-ahead out/get/empty. The head word is valid whenever empty=0, and get pops it.
- Sits between a data source and a prefetch stage. Decouples bursts and provides the registered empty flag the consumer samples.

Parameters:
- W, 8, data width in bits
- N, 4, log2 of depth; depth D = 2^N entries

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- in  input  W  write data, sampled when put accepted
- put  input  1  write request
- full  output  1  registered, 1 = no free entry
- out  output  W  head entry (show-ahead), valid when empty=0
- get  input  1  pop request
- empty  output  1  registered, 1 = no valid entry
- level  output  N+1  occupancy 0..D (FIFO_LEVEL_EN only)
- error  output  2  sticky {overrun, underrun} (FIFO_LEVEL_EN only)

Behaviour:
- Reset:
  - Synchronous, active-high; reset dominates all other inputs.
  - Sets wp=0, rp=0, empty=1, full=0, level=0, error=0.
  - Storage contents are not reset.
- Pointers and storage:
  - Pointers wp and rp are N+1 bits wide. Storage is indexed by the low N bits; the MSB is the wrap bit.
  - Storage is D x W, written on the clock edge and read asynchronously: out = mem[rp[N-1:0]].
  - out is don't-care while empty=1.
- Accept rules (use registered flags only):
  - we = put & !full
  - re = get & !empty
  - put while full: ignored, data dropped, wp unchanged.
  - get while empty: ignored, rp unchanged.
- Per edge:
  - we: mem[wp] <= in; wp <= wp+1 (mod 2^(N+1)).
  - re: rp <= rp+1.
- Flag update, computed from next pointers:
  - empty <= (wp_n == rp_n)
  - full <= (wp_n[N] != rp_n[N]) && (wp_n[N-1:0] == rp_n[N-1:0])
- Latency:
  - Word put at edge t is visible on out with empty=0 from edge t (cycle t+1 onward). Write-to-read latency is 1 cycle, no fall-through.
  - A pop at edge t frees its slot; full drops after edge t, and a put in cycle t+1 is accepted.
- Simultaneous put and get:
  - Neither full nor empty: both accepted, occupancy unchanged, flags unchanged.
  - Full: the get is accepted and the put is ignored. Occupancy becomes D-1 and full drops.
  - Empty: the put is accepted and the get is ignored. Occupancy becomes 1 and empty drops.
- Wrap-around: pointers roll over naturally. Ordering is preserved across any number of wraps.
- Reset mid-operation:
  - All contents are discarded; empty=1 on the next cycle.
  - A put or get in the reset cycle is ignored.
- Consumer compatibility: empty is registered, and out is stable until the edge on which re occurs. This meets the prefetch-stage timing: get registered, data sampled on a later edge.

Optional Feature:
- Macro: FIFO_LEVEL_EN
- Defined:
  - level and error ports are present.
  - level is a registered count updated each edge: +1 on we only, -1 on re only, unchanged otherwise. Invariant: level == wp - rp.
  - error[1] (overrun) sets on put & full.
  - error[0] (underrun) sets on get & empty.
  - Both error bits are sticky until reset.
- Undefined: level and error ports and their logic are absent. Flags and data behaviour are identical.

Test Plan:
- Reset, W=8, N=2 (D=4): after reset, empty=1, full=0, level=0, error=00.
- Fill and drain: put 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - full=1 after the 4th edge; level=4.
  - get x4 yields out 0x11, 0x22, 0x33, 0x44 in order; empty=1 after the 4th pop.
- Overrun: with the FIFO full, put 0x55. Data is dropped, error=10, and later reads never show 0x55. Then get, and put 0x66 on the next cycle: accepted.
- Simultaneous put and get at full and at empty:
  - At full: level 4 becomes 3 and full=0.
  - At empty with put 0x77: empty=0 next cycle, out=0x77, error[0]=0.
- Wrap: stream 0x00..0x13 (20 words) with random put/get gaps. Output order matches exactly, and level never exceeds 4.
- Mid-stream reset with 3 entries held: empty=1, level=0 next cycle. A put in the same cycle as reset is ignored.

Source files
------------

// File: rtl/fifo_sync.sv
// Synchronous single-clock show-ahead FIFO with registered full/empty flags.
// Define FIFO_LEVEL_EN to add the occupancy (level) and sticky error ports.
module fifo_sync #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in,
    input  logic         put,
    output logic         full,
    output logic [W-1:0] out,
    input  logic         get,
    output logic         empty
`ifdef FIFO_LEVEL_EN
    ,
    output logic [N:0]   level,
    output logic [1:0]   error
`endif
);

    localparam int D = 1 << N;
    localparam logic [N:0] PTR_ONE = {{N{1'b0}}, 1'b1};

    logic [W-1:0] mem_r [D];
    logic [N:0]   wp_r;
    logic [N:0]   rp_r;
    logic [N:0]   wp_n_s;
    logic [N:0]   rp_n_s;
    logic         we_s;
    logic         re_s;
    logic         full_r;
    logic         empty_r;

    // Accept decisions use only the registered flags, so put/get never see a combinational path.
    always_comb begin
        we_s   = put & ~full_r;
        re_s   = get & ~empty_r;
        wp_n_s = wp_r;
        rp_n_s = rp_r;
        if (we_s) begin
            wp_n_s = wp_r + PTR_ONE;
        end else begin
            wp_n_s = wp_r;
        end
        if (re_s) begin
            rp_n_s = rp_r + PTR_ONE;
        end else begin
            rp_n_s = rp_r;
        end
    end

    // Pointer and flag registers; flags are derived from the next pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wp_r    <= {(N+1){1'b0}};
            rp_r    <= {(N+1){1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            wp_r    <= wp_n_s;
            rp_r    <= rp_n_s;
            empty_r <= (wp_n_s == rp_n_s);
            full_r  <= (wp_n_s[N] != rp_n_s[N]) && (wp_n_s[N-1:0] == rp_n_s[N-1:0]);
        end
    end

    // Storage write; contents are deliberately not cleared by reset.
    always_ff @(posedge clock) begin
        if (we_s && !reset) begin
            mem_r[wp_r[N-1:0]] <= in;
        end
    end

    assign out   = mem_r[rp_r[N-1:0]];
    assign full  = full_r;
    assign empty = empty_r;

`ifdef FIFO_LEVEL_EN
    logic [N:0] level_r;
    logic [1:0] error_r;

    // Occupancy counter and sticky {overrun, underrun} flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_r <= {(N+1){1'b0}};
            error_r <= 2'b00;
        end else begin
            case ({we_s, re_s})
                2'b10:   level_r <= level_r + PTR_ONE;
                2'b01:   level_r <= level_r - PTR_ONE;
                default: level_r <= level_r;
            endcase
            error_r[1] <= error_r[1] | (put & full_r);
            error_r[0] <= error_r[0] | (get & empty_r);
        end
    end

    assign level = level_r;
    assign error = error_r;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync (W=8, N=2): vector table, corner sequences and a data scoreboard.
module tb_fifo_sync;
    localparam int W = 8;
    localparam int N = 2;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         put;
    logic         get;
    logic [W-1:0] in;
    logic [W-1:0] out;
    logic         full;
    logic         empty;
`ifdef FIFO_LEVEL_EN
    logic [N:0]   level;
    logic [1:0]   error;
`endif

    fifo_sync #(.W(W), .N(N)) dut (
        .clock (clock),
        .reset (reset),
        .in    (in),
        .put   (put),
        .full  (full),
        .out   (out),
        .get   (get),
        .empty (empty)
`ifdef FIFO_LEVEL_EN
        ,
        .level (level),
        .error (error)
`endif
    );

    always #5 clock = ~clock;

    int           compared   = 0;
    int           mismatched = 0;
    logic [W-1:0] sb [$];
    int           cnt  = 0;
    int           recv = 0;
    logic [1:0]   merr = 2'b00;

    typedef struct {
        logic         r;
        logic         p;
        logic         g;
        logic [W-1:0] d;
        logic         e;
        logic         f;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive on negedge, pop-compare head, then check flags after the edge.
    task automatic step(input logic r, input logic p, input logic g, input logic [W-1:0] d);
        logic we;
        logic re;
        @(negedge clock);
        reset = r;
        put   = p;
        get   = g;
        in    = d;
        we = !r && p && (cnt < D);
        re = !r && g && (cnt > 0);
        if (re) begin
            chk("pop_data", {24'd0, out}, {24'd0, sb[0]});
            void'(sb.pop_front());
            recv++;
        end
        if (we) sb.push_back(d);
        if (!r) begin
            if (p && cnt == D) merr[1] = 1'b1;
            if (g && cnt == 0) merr[0] = 1'b1;
        end
        @(posedge clock);
        #1;
        if (r) begin
            cnt = 0;
            sb.delete();
            merr = 2'b00;
        end else begin
            cnt = cnt + int'(we) - int'(re);
        end
        chk("empty", {31'd0, empty}, {31'd0, cnt == 0});
        chk("full", {31'd0, full}, {31'd0, cnt == D});
`ifdef FIFO_LEVEL_EN
        chk("level", {29'd0, level}, cnt);
        chk("error", {30'd0, error}, {30'd0, merr});
`endif
    endtask

    initial begin
        reset = 1'b1;
        put   = 1'b0;
        get   = 1'b0;
        in    = 8'h00;

        vt[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1};
        vt[5] = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1};
        vt[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[9] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

        // Reset, fill, overrun with 0x55, drain.
        for (int i = 0; i < 10; i++) begin
            step(vt[i].r, vt[i].p, vt[i].g, vt[i].d);
            chk($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, vt[i].e});
            chk($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vt[i].f});
        end
        chk("drained_after_vec", recv, 4);

        // Refill, pop once, then a put on the next cycle is accepted.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i));
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("pop_frees_full", {31'd0, full}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h66);
        chk("put_after_pop_full", {31'd0, full}, 32'd1);

        // Simultaneous put/get while full: get wins, full drops.
        step(1'b0, 1'b1, 1'b1, 8'h88);
        chk("simul_full", {31'd0, full}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("empty_before_simul", {31'd0, empty}, 32'd1);

        // Simultaneous put/get while empty: put wins, head shows new word.
        step(1'b0, 1'b1, 1'b1, 8'h77);
        chk("simul_empty_flag", {31'd0, empty}, 32'd0);
        chk("simul_empty_out", {24'd0, out}, 32'h77);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // Stream 20 words across several pointer wraps with random gaps.
        begin
            int sent;
            int base;
            int cycles;
            logic p;
            logic g;
            sent   = 0;
            base   = recv;
            cycles = 0;
            while ((recv - base < 20) && (cycles < 400)) begin
                p = (sent < 20) && ($urandom_range(0, 2) != 0);
                g = ($urandom_range(0, 1) != 0);
                if (p && cnt < D) begin
                    step(1'b0, 1'b1, g, 8'(sent));
                    sent++;
                end else begin
                    step(1'b0, p, g, 8'(sent));
                end
                cycles++;
            end
            chk("wrap_words_received", recv - base, 20);
        end

        // Reset with 3 entries held; the put in the reset cycle is dropped.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'hC0 + 8'(i));
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        chk("midreset_empty", {31'd0, empty}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("midreset_put_ignored", {31'd0, empty}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
